// File: rtl/tx_burst_controller.sv
// tx_burst_controller: frames the PRBS/QPSK/bandpass chain into warm-up, payload, tail and guard-gap bursts
//   ip_clock       rising-edge clock
//   ip_reset       synchronous active-low reset
//   ip_start       burst request, honoured only in IDLE
//   ip_abort       ends the active burst (WARMUP/BURST/TAIL only)
//   ip_continuous  at the end of GAP, start the next burst automatically
//   ip_burst_len   payload length in cycles, latched at burst start (0 rejects)
//   ip_if          IF sample from the modulator chain
//   op_mod_enable  modulator chain enable
//   op_if          gated IF sample, 0 outside the payload
//   op_if_valid    payload sample qualifier
//   op_busy        high in every state except IDLE
//   op_done        one-cycle pulse on normal completion
//   op_aborted     one-cycle pulse on abort
//   op_sent        valid samples in the current or most recent burst (saturating)
//   op_bursts      completed, non-aborted bursts (wrapping)
module tx_burst_controller #(
    parameter int FLUSH_LEN = 16,
    parameter int PIPE_LAT  = 3,
    parameter int GAP_LEN   = 32
) (
    input  logic               ip_clock,
    input  logic               ip_reset,
    input  logic               ip_start,
    input  logic               ip_abort,
    input  logic               ip_continuous,
    input  logic [15:0]        ip_burst_len,
    input  logic signed [11:0] ip_if,
    output logic               op_mod_enable,
    output logic signed [11:0] op_if,
    output logic               op_if_valid,
    output logic               op_busy,
    output logic               op_done,
    output logic               op_aborted,
    output logic [15:0]        op_sent,
    output logic [7:0]         op_bursts
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WARMUP = 3'd1;
    localparam logic [2:0] BURST  = 3'd2;
    localparam logic [2:0] TAIL   = 3'd3;
    localparam logic [2:0] GAP    = 3'd4;
    localparam logic [15:0] WARM_LAST = 16'(FLUSH_LEN - 1);
    localparam logic [15:0] TAIL_LAST = 16'(PIPE_LAT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);

    logic [2:0]          state, state_n;
    logic [15:0]         cnt, cnt_n, len, len_n;
    logic                abort_gap;
    logic [PIPE_LAT-1:0] line, line_n;
    logic                burst_flag, pre, last, active, abort_go, done_go, start_go;

    assign last       = cnt == 16'd0;
    assign active     = state == WARMUP || state == BURST || state == TAIL;
    assign abort_go   = active && ip_abort;
    assign done_go    = state == TAIL && last && !ip_abort;
    assign burst_flag = state == BURST;
    assign op_if_valid = line[PIPE_LAT-1];

    // pre is the flag one stage ahead of op_if_valid, so op_if lines up with it
    if (PIPE_LAT == 1) begin : g_short
        assign pre    = burst_flag;
        assign line_n = burst_flag;
    end else begin : g_long
        assign pre    = line[PIPE_LAT-2];
        assign line_n = {line[PIPE_LAT-2:0], burst_flag};
    end

    always_comb begin
        state_n  = state;
        cnt_n    = last ? cnt : cnt - 16'd1;
        len_n    = len;
        start_go = 1'b0;
        case (state)
            IDLE: if (ip_start && ip_burst_len != 16'd0) begin
                state_n  = WARMUP;
                cnt_n    = WARM_LAST;
                len_n    = ip_burst_len;
                start_go = 1'b1;
            end
            WARMUP: if (last) begin
                state_n = BURST;
                cnt_n   = len - 16'd1;
            end
            BURST: if (last) begin
                state_n = TAIL;
                cnt_n   = TAIL_LAST;
            end
            TAIL: if (last) begin
                state_n = GAP;
                cnt_n   = GAP_LAST;
            end
            GAP: if (last) begin
                // an aborted burst never chains into another one
                if (ip_continuous && !abort_gap && ip_burst_len != 16'd0) begin
                    state_n  = WARMUP;
                    cnt_n    = WARM_LAST;
                    len_n    = ip_burst_len;
                    start_go = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_go) begin
            state_n = GAP;
            cnt_n   = GAP_LAST;
        end
    end

    always_ff @(posedge ip_clock) begin
        if (!ip_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            len           <= '0;
            abort_gap     <= 1'b0;
            line          <= '0;
            op_if         <= '0;
            op_mod_enable <= 1'b0;
            op_busy       <= 1'b0;
            op_done       <= 1'b0;
            op_aborted    <= 1'b0;
            op_sent       <= '0;
            op_bursts     <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            len           <= len_n;
            abort_gap     <= abort_go ? 1'b1 : start_go ? 1'b0 : abort_gap;
            line          <= abort_go ? '0 : line_n;
            op_if         <= (pre && !abort_go) ? ip_if : '0;
            op_mod_enable <= state_n == WARMUP || state_n == BURST || state_n == TAIL;
            op_busy       <= state_n != IDLE;
            op_done       <= done_go;
            op_aborted    <= abort_go;
            op_sent       <= start_go ? '0 : (op_if_valid && op_sent != 16'hFFFF) ? op_sent + 16'd1 : op_sent;
            op_bursts     <= op_bursts + {7'd0, done_go};
        end
    end
endmodule
